// File: rtl/mult_4_seq_core.sv
// mult_4_seq_core
//   Sequential shift-and-add unsigned multiplier. One WIDTH x WIDTH product is
//   computed per accepted start request. The core retires one multiplier bit
//   per clock, so latency does not depend on the operand values.
//
// Ports
//   clk      in   1        system clock; all state changes on the rising edge
//   rst      in   1        synchronous, active-high reset
//   start    in   1        request; only sampled while idle
//   a        in   WIDTH    multiplicand (unsigned), captured on accepted start
//   b        in   WIDTH    multiplier (unsigned), captured on accepted start
//   busy     out  1        high while the shift-and-add loop is running
//   done     out  1        single-cycle completion pulse
//   product  out  2*WIDTH  registered a*b, held until the next completion
module mult_4_seq_core #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW    = 2 * WIDTH;
  // Iteration counter runs 0 .. WIDTH-1; keep at least one bit for WIDTH=1.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q,   state_d;
  logic [PW-1:0]     mcand_q,   mcand_d;
  logic [WIDTH-1:0]  mplier_q,  mplier_d;
  logic [PW-1:0]     acc_q,     acc_d;
  logic [CNT_W-1:0]  count_q,   count_d;
  logic [PW-1:0]     product_q, product_d;

  logic [PW-1:0]     acc_next;

  // Conditional add of the shifted multiplicand. The accumulator is 2*WIDTH
  // bits, which always holds (2^WIDTH-1)^2, so the sum never wraps.
  function automatic logic [PW-1:0] add_partial(
    input logic [PW-1:0] acc,
    input logic [PW-1:0] mcand,
    input logic          mbit
  );
    logic [PW-1:0] sum;
    sum = acc;
    if (mbit) begin
      sum = acc + mcand;
    end
    return sum;
  endfunction

  assign acc_next = add_partial(acc_q, mcand_q, mplier_q[0]);

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, a};
          mplier_d = b;
          acc_d    = '0;
          count_d  = '0;
          state_d  = ST_RUN;
        end
      end

      ST_RUN: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CNT_W'(1);
        // Last bit: publish the sum that includes this edge's partial product.
        if (count_q == LAST_CNT) begin
          product_d = acc_next;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  // Outputs are pure decodes of the registered state, so busy and done are
  // mutually exclusive by construction.
  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_mult_4_seq_core.sv
module tb_mult_4_seq_core;

  localparam int WIDTH = 4;
  localparam int PW    = 2 * WIDTH;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [PW-1:0]    product;

  mult_4_seq_core #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Behavioural reference: the result is a plain a*b taken when a request is
  // accepted, released WIDTH edges later for one cycle.
  int            m_mode  = 0;   // 0 idle, 1 running, 2 completing
  int            m_left  = 0;
  logic [PW-1:0] m_res   = '0;
  logic [PW-1:0] m_prod  = '0;
  bit            m_valid = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_mode  = 0;
      m_prod  = '0;
      m_valid = 1;
    end else if (m_valid) begin
      case (m_mode)
        0: if (start) begin
             m_res  = PW'(int'(a) * int'(b));
             m_left = WIDTH;
             m_mode = 1;
           end
        1: begin
             m_left--;
             if (m_left == 0) begin
               m_prod = m_res;
               m_mode = 2;
             end
           end
        default: m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy",    busy,    (m_mode == 1));
      chk("done",    done,    (m_mode == 2));
      chk("product", product, m_prod);
      if (busy && done) chk("busy_and_done", 1, 0);
      if (done) done_cnt++;
    end
  end

  // Launch one request: start is high for exactly the accept edge t0.
  // Returns just after t0 with start already low.
  task automatic launch(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    @(posedge clk); #2;
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  // Wait for done; lat counts negedges after t0 (0 = cycle after t0).
  task automatic wait_done(output int lat, output int nbusy);
    lat = -1;
    nbusy = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      if (busy) nbusy++;
      if (done) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) chk("done_timeout", 0, 1);
  endtask

  int lat, nb, d0, last_done_cyc;

  initial begin
    rst = 1'b1; start = 1'b1; a = 4'd3; b = 4'd3;

    // Reset held with start high
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_product", product, 0);
    @(posedge clk); #2;
    rst = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("post_rst_idle", busy, 0);

    // Basic 7*3
    launch(4'd7, 4'd3);
    wait_done(lat, nb);
    chk("basic_latency", lat, 4);
    chk("basic_busy_cycles", nb, 4);
    chk("basic_product", product, 8'h15);
    repeat (3) @(negedge clk);
    #1 chk("basic_hold", product, 8'h15);

    // Max operands
    launch(4'd15, 4'd15);
    wait_done(lat, nb);
    chk("max_latency", lat, 4);
    chk("max_product", product, 8'hE1);

    // Zero multiplicand still takes the full latency
    launch(4'd0, 4'd9);
    wait_done(lat, nb);
    chk("zero_latency", lat, 4);
    chk("zero_product", product, 8'h00);
    repeat (2) @(posedge clk);

    // Operand capture and ignored start during RUN
    d0 = done_cnt;
    launch(4'd5, 4'd6);
    @(posedge clk); #2;
    a = 4'd15; b = 4'd15; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done(lat, nb);
    chk("capture_product", product, 8'h1E);
    repeat (8) @(negedge clk);
    #1;
    chk("capture_single_done", done_cnt - d0, 1);
    chk("capture_no_relaunch", busy, 0);

    // Reset during RUN at the second RUN edge
    d0 = done_cnt;
    launch(4'd9, 4'd9);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_product", product, 0);
    repeat (6) @(negedge clk);
    #1 chk("midrst_no_done", done_cnt - d0, 0);
    launch(4'd9, 4'd9);
    wait_done(lat, nb);
    chk("after_rst_product", product, 8'h51);
    repeat (2) @(posedge clk);

    // Back-to-back sweep with start held high
    @(posedge clk); #2;
    a = 4'd0; b = 4'd0; start = 1'b1;
    last_done_cyc = 0;
    for (int p = 0; p < 256; p++) begin
      logic [WIDTH-1:0] ca, cb;
      bit got;
      ca = p[3:0];
      cb = p[7:4];
      got = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (done) begin
          got = 1;
          break;
        end
      end
      if (!got) begin
        chk("sweep_timeout", 0, 1);
        break;
      end
      chk("sweep_product", product, int'(ca) * int'(cb));
      if (p > 0) chk("sweep_spacing", cyc - last_done_cyc, 6);
      last_done_cyc = cyc;
      if (p < 255) begin
        a = 4'((p + 1) % 16);
        b = 4'((p + 1) / 16);
      end
    end
    start = 1'b0;
    repeat (8) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
